// File: rtl/beat_sequencer.sv
// Beat-driven step sequencer: rising edges of pulse advance a per-channel
// STEPS-long pattern and fire fixed-width triggers, counting bars and a downbeat LED.
module beat_sequencer #(
    parameter  int CHANNELS = 4,
    parameter  int STEPS    = 16,
    parameter  int TRIG_W   = 4,
    localparam int SW       = $clog2(STEPS),
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pulse,
    input  logic                start,
    input  logic                stop,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [STEPS-1:0]    wr_data,
    output logic [CHANNELS-1:0] trig,
    output logic [SW-1:0]       step,
    output logic [7:0]          bar_count,
    output logic                led,
    output logic                busy
);

    localparam logic [7:0] TW = 8'(TRIG_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic                  pulse_d;
    logic                  beat;
    logic [STEPS-1:0]      pattern [CHANNELS];
    logic [7:0]            width_cnt, width_cnt_nx;
    logic [SW-1:0]         step_nx, fire_step;
    logic [7:0]            bar_nx;
    logic [CHANNELS-1:0]   trig_nx;
    logic                  led_nx, busy_nx, fire;

    assign beat = pulse & ~pulse_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pulse_d   <= 1'b0;
            step      <= '0;
            bar_count <= '0;
            trig      <= '0;
            width_cnt <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            pulse_d   <= pulse;
            step      <= step_nx;
            bar_count <= bar_nx;
            trig      <= trig_nx;
            width_cnt <= width_cnt_nx;
            led       <= led_nx;
            busy      <= busy_nx;
        end
    end

    // Writes land on the clock edge, so a fire on the same edge still sees the old pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) pattern[c] <= '0;
        end else if (wr_en && (int'(wr_ch) < CHANNELS)) begin
            pattern[wr_ch] <= wr_data;
        end
    end

    always_comb begin
        state_nx     = state;
        step_nx      = step;
        bar_nx       = bar_count;
        trig_nx      = trig;
        width_cnt_nx = width_cnt;
        fire         = 1'b0;
        fire_step    = step;

        if (stop) begin
            state_nx     = S_IDLE;
            step_nx      = '0;
            trig_nx      = '0;
            width_cnt_nx = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state_nx = S_ARMED;
                end
                S_ARMED: begin
                    if (beat) begin
                        state_nx  = S_PLAY;
                        fire      = 1'b1;
                        fire_step = '0;
                    end
                end
                S_PLAY: begin
                    if (beat) begin
                        fire      = 1'b1;
                        fire_step = step + 1'b1;
                        step_nx   = fire_step;
                        if (step == {SW{1'b1}}) bar_nx = bar_count + 8'd1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase

            // A fire reloads the width counter and re-evaluates every channel (retrigger).
            if (fire) begin
                for (int c = 0; c < CHANNELS; c++) trig_nx[c] = pattern[c][fire_step];
                width_cnt_nx = TW;
            end else if (width_cnt != 8'd0) begin
                width_cnt_nx = width_cnt - 8'd1;
                if (width_cnt == 8'd1) trig_nx = '0;
            end
        end

        led_nx  = (state_nx == S_PLAY) && (step_nx == '0);
        busy_nx = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed scenarios plus random traffic,
// compared every cycle against a beat-count based reference model.
module tb_beat_sequencer;

    localparam int CH = 4;
    localparam int ST = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pulse = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [15:0]   wr_data = '0;
    logic [3:0]    trig;
    logic [3:0]    step;
    logic [7:0]    bar_count;
    logic          led;
    logic          busy;

    int vectors = 0;
    int errors  = 0;

    // Reference model: beats since arming, bars banked before the last stop.
    logic [15:0] m_pat [CH];
    logic        m_prev;
    bit          m_armed, m_playing;
    int          m_n, m_bars_base, m_left;
    logic [3:0]  m_trig;

    int hi0, hi2;
    bit count_en = 1'b0;

    beat_sequencer #(.CHANNELS(CH), .STEPS(ST), .TRIG_W(TW)) dut (
        .clk(clk), .reset(reset), .pulse(pulse), .start(start), .stop(stop),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .trig(trig), .step(step), .bar_count(bar_count), .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_step();
        return m_playing ? (m_n - 1) % ST : 0;
    endfunction

    function automatic int exp_bar();
        return (m_bars_base + (m_playing ? (m_n - 1) / ST : 0)) % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) m_pat[c] = '0;
        m_prev = 1'b0; m_armed = 0; m_playing = 0;
        m_n = 0; m_bars_base = 0; m_left = 0; m_trig = '0;
    endtask

    task automatic model_edge();
        bit b, fire;
        int s;
        if (!reset) begin
            model_reset();
            return;
        end
        b = pulse && !m_prev;
        m_prev = pulse;
        fire = 0;
        if (stop) begin
            if (m_playing) m_bars_base += (m_n - 1) / ST;
            m_armed = 0; m_playing = 0; m_n = 0; m_trig = '0; m_left = 0;
        end else begin
            if (!m_armed && !m_playing) begin
                if (start) m_armed = 1;
            end else if (m_armed) begin
                if (b) begin m_armed = 0; m_playing = 1; m_n = 1; fire = 1; end
            end else if (b) begin
                m_n++; fire = 1;
            end
            if (fire) begin
                s = (m_n - 1) % ST;
                for (int c = 0; c < CH; c++) m_trig[c] = m_pat[c][s];
                m_left = TW;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_trig = '0;
            end
        end
        if (wr_en && int'(wr_ch) < CH) m_pat[wr_ch] = wr_data;
    endtask

    task automatic compare();
        chk("trig", 32'(trig), 32'(m_trig));
        chk("step", 32'(step), 32'(exp_step()));
        chk("bar_count", 32'(bar_count), 32'(exp_bar()));
        chk("led", 32'(led), 32'(m_playing && exp_step() == 0));
        chk("busy", 32'(busy), 32'(m_armed || m_playing));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        if (count_en) begin
            hi0 += int'(trig[0]);
            hi2 += int'(trig[2]);
        end
    endtask

    task automatic beat(input int hi, input int lo);
        pulse = 1'b1;
        repeat (hi) tick();
        pulse = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic write(input logic [1:0] ch, input logic [15:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Beat until the model sits at the requested step; bounded so it always returns.
    task automatic beat_to_step(input int target);
        for (int i = 0; i < 2 * ST && exp_step() != target; i++) beat(1, 1);
        chk("reach_step", 32'(step), 32'(target));
    endtask

    initial begin
        int bar0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        reset = 1'b1;

        // 1: basic firing
        write(2'd0, 16'h0001);
        write(2'd1, 16'hFFFF);
        pulse_start();
        chk("t1_busy_armed", 32'(busy), 32'd1);
        pulse = 1'b1; tick();
        chk("t1_b1_trig", 32'(trig), 32'h3);
        chk("t1_b1_step", 32'(step), 32'd0);
        chk("t1_b1_led", 32'(led), 32'd1);
        pulse = 1'b0; repeat (3) tick();
        chk("t1_b1_trig_last", 32'(trig), 32'h3);
        tick();
        chk("t1_b1_trig_clear", 32'(trig), 32'h0);
        beat(1, 4);
        chk("t1_b2_step", 32'(step), 32'd1);
        beat(1, 0);
        chk("t1_b3_trig", 32'(trig), 32'h2);
        chk("t1_b3_step", 32'(step), 32'd2);
        tick();

        // 2: bar wrap and 256-bar rollover
        beat_to_step(ST - 1);
        bar0 = int'(bar_count);
        beat(1, 0);
        chk("t2_wrap_step", 32'(step), 32'd0);
        chk("t2_wrap_bar", 32'(bar_count), 32'((bar0 + 1) % 256));
        chk("t2_wrap_led", 32'(led), 32'd1);
        tick();
        repeat (256 * ST) beat(1, 1);
        chk("t2_rollover_bar", 32'(bar_count), 32'((bar0 + 1) % 256));

        // 3: long pulses advance once each
        for (int i = 0; i < 3; i++) begin
            int s0;
            s0 = int'(step);
            beat(50, 3);
            chk("t3_one_advance", 32'(step), 32'((s0 + 1) % ST));
        end

        // 4: stop inside a trigger window
        beat_to_step(4);
        beat(1, 2);
        chk("t4_step5", 32'(step), 32'd5);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t4_trig", 32'(trig), 32'h0);
        chk("t4_step", 32'(step), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (3) beat(1, 3);
        chk("t4_no_trig", 32'(trig), 32'h0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("t4_stop_wins", 32'(busy), 32'd0);

        // 5: retrigger
        write(2'd0, 16'h0003);
        write(2'd1, 16'h0000);
        write(2'd2, 16'h0001);
        pulse_start();
        hi0 = 0; hi2 = 0; count_en = 1'b1;
        beat(1, 1);
        beat(1, 8);
        count_en = 1'b0;
        chk("t5_ch0_width", 32'(hi0), 32'(2 + TW));
        chk("t5_ch2_width", 32'(hi2), 32'd2);

        // 6: write colliding with a fire, then async reset
        write(2'd3, 16'h0000);
        beat_to_step(2);
        pulse = 1'b1; wr_en = 1'b1; wr_ch = 2'd3; wr_data = 16'h0008;
        tick();
        wr_en = 1'b0;
        chk("t6_old_pattern", 32'(trig[3]), 32'd0);
        chk("t6_step3", 32'(step), 32'd3);
        pulse = 1'b0; tick();
        beat_to_step(2);
        beat(1, 1);
        chk("t6_new_pattern", 32'(trig[3]), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        pulse = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        pulse = 1'b0;
        tick();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) pulse = ~pulse;
            start   = ($urandom_range(0, 19) == 0);
            stop    = ($urandom_range(0, 79) == 0);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_data = 16'($urandom);
            tick();
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
